// File: rtl/fsm_arb_pkg.sv
// Shared definitions for the round-robin arbiter FSM: state encoding,
// default sizing constants and the rotating priority select function.
package fsm_arb_pkg;

    localparam int ARB_N_DEFAULT        = 4;
    localparam int ARB_MAX_HOLD_DEFAULT = 8;
    localparam int ARB_N_MAX            = 8;

    // State encoding kept as plain constants so netlists and older tools see fixed codes
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE    = 2'b00;
    localparam arb_state_t ST_GRANT   = 2'b01;
    localparam arb_state_t ST_RELEASE = 2'b10;

    // Index of the first set request found scanning ptr, ptr+1, ... mod n.
    // Returns 0 when nothing is set; callers only use it when req is non-zero.
    function automatic logic [2:0] rr_select(input logic [ARB_N_MAX-1:0] req,
                                             input logic [2:0]           ptr,
                                             input int                   n);
        logic [2:0] sel;
        logic       found;
        int         idx;
        sel   = 3'd0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < ARB_N_MAX; i++) begin
            if (i < n) begin
                idx = int'(ptr) + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && req[idx]) begin
                    sel   = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/fsm_hold_counter.sv
// Grant-length counter for the arbiter's force-release feature.
// Counts GRANT cycles; tc flags the last cycle a grant may be held.
module fsm_hold_counter #(
    parameter int MAX_HOLD = 8
) (
    input  logic clk,
    input  logic nRst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [7:0] count_reg;

    // Up-counter: clear wins over enable so a fresh grant always starts at zero
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            count_reg <= 8'd0;
        end else if (clr) begin
            count_reg <= 8'd0;
        end else if (en) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign tc = (count_reg == 8'(MAX_HOLD - 1));

endmodule

// File: rtl/fsm_rr_arbiter.sv
// Round-robin arbiter FSM (IDLE -> GRANT -> RELEASE) with registered one-hot
// grant. Optional force-release of over-long grants: define FSM_ARB_TIMEOUT_EN.
module fsm_rr_arbiter
    import fsm_arb_pkg::*;
#(
    parameter int N        = ARB_N_DEFAULT,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 timeout
);

    localparam int IW = $clog2(N);

    // Elaboration-time range checks on the configuration
    if (N < 2 || N > ARB_N_MAX) begin : g_bad_n
        $error("fsm_rr_arbiter: N must be in 2..8");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("fsm_rr_arbiter: MAX_HOLD must be in 2..255");
    end

    arb_state_t             state_reg, state_next;
    logic [IW-1:0]          ptr_reg, ptr_next;
    logic [IW-1:0]          gnt_id_reg, gnt_id_next;
    logic [N-1:0]           grant_reg, grant_next;
    logic                   busy_reg;
    logic [ARB_N_MAX-1:0]   req_ext;
    logic [IW-1:0]          sel_id;
    logic [N-1:0]           sel_onehot;
    logic                   rel_normal;
    logic                   force_rel;

    // Widen the request vector to the select function's fixed width
    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
    end

    assign sel_id = IW'(rr_select(req_ext, 3'(ptr_reg), N));

    // One-hot decode of the selected requester
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
        assign sel_onehot[gi] = (sel_id == IW'(gi));
    end

    // The owner lets go either explicitly or by withdrawing its request
    assign rel_normal = done || !req[gnt_id_reg];

`ifdef FSM_ARB_TIMEOUT_EN
    logic hold_tc;
    logic timeout_reg;

    fsm_hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_counter (
        .clk  (clk),
        .nRst (nRst),
        .clr  (state_reg == ST_IDLE),
        .en   (state_reg == ST_GRANT),
        .tc   (hold_tc)
    );

    assign force_rel = hold_tc;

    // Timeout pulse lines up with the RELEASE cycle caused by a forced release
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= (state_reg == ST_GRANT) && !rel_normal && hold_tc;
        end
    end

    assign timeout = timeout_reg;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    // Next-state, grant and pointer selection
    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        gnt_id_next = gnt_id_reg;
        grant_next  = grant_reg;
        case (state_reg)
            ST_IDLE: begin
                grant_next = '0;
                if (req != '0) begin
                    grant_next  = sel_onehot;
                    gnt_id_next = sel_id;
                    state_next  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (rel_normal || force_rel) begin
                    grant_next = '0;
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                grant_next = '0;
                ptr_next   = (gnt_id_reg == IW'(N - 1)) ? '0 : gnt_id_reg + 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                grant_next = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers; gnt_id is only rewritten on a new grant
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_reg  <= ST_IDLE;
            ptr_reg    <= '0;
            gnt_id_reg <= '0;
            grant_reg  <= '0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            gnt_id_reg <= gnt_id_next;
            grant_reg  <= grant_next;
            busy_reg   <= (state_next != ST_IDLE);
        end
    end

    assign grant  = grant_reg;
    assign gnt_id = gnt_id_reg;
    assign busy   = busy_reg;

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Directed testbench for fsm_rr_arbiter (N=4, MAX_HOLD=8). The timeout
// scenario adapts to whether FSM_ARB_TIMEOUT_EN is defined.
module tb_fsm_rr_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic         clk = 1'b0;
    logic         nRst = 1'b0;
    logic [N-1:0] req = '0;
    logic         done = 1'b0;
    logic [N-1:0] grant;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         timeout;

    int total = 0;
    int bad   = 0;

    logic [3:0] rot_grant [4];
    logic [1:0] rot_id    [4];

    fsm_rr_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .nRst    (nRst),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("chk %s: value=%0h ok", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release current grant via done, check the two idle cycles, land on next grant
    task automatic release_and_regrant(input string tag);
        done = 1'b1;
        tick();
        check_val({tag, "_rel_grant"}, 32'(grant), 32'h0);
        check_val({tag, "_rel_busy"}, 32'(busy), 32'h1);
        done = 1'b0;
        tick();
        check_val({tag, "_idle_grant"}, 32'(grant), 32'h0);
        check_val({tag, "_idle_busy"}, 32'(busy), 32'h0);
        tick();
    endtask

    initial begin
        rot_grant[0] = 4'b0010; rot_id[0] = 2'd1;
        rot_grant[1] = 4'b0100; rot_id[1] = 2'd2;
        rot_grant[2] = 4'b1000; rot_id[2] = 2'd3;
        rot_grant[3] = 4'b0001; rot_id[3] = 2'd0;

        // Reset with all requests pending
        req  = 4'b1111;
        nRst = 1'b0;
        tick();
        tick();
        check_val("rst_grant", 32'(grant), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_timeout", 32'(timeout), 32'h0);
        check_val("rst_gnt_id", 32'(gnt_id), 32'h0);
        nRst = 1'b1;
        tick();
        check_val("first_grant", 32'(grant), 32'h1);
        check_val("first_gnt_id", 32'(gnt_id), 32'h0);
        check_val("first_busy", 32'(busy), 32'h1);

        // Rotation with wrap-around
        for (int i = 0; i < 4; i++) begin
            release_and_regrant("rot");
            check_val("rot_grant", 32'(grant), 32'(rot_grant[i]));
            check_val("rot_gnt_id", 32'(gnt_id), 32'(rot_id[i]));
        end

        // Skip: ptr=1 after granting requester 0
        req = 4'b1001;
        release_and_regrant("skip1");
        check_val("skip_grant3", 32'(grant), 32'h8);
        release_and_regrant("skip2");
        check_val("skip_grant0", 32'(grant), 32'h1);

        // Withdraw: requester 2 drops its request while granted
        req = 4'b0100;
        release_and_regrant("wd");
        check_val("wd_grant", 32'(grant), 32'h4);
        req = 4'b0000;
        tick();
        check_val("wd_rel_grant", 32'(grant), 32'h0);
        check_val("wd_rel_busy", 32'(busy), 32'h1);
        check_val("wd_rel_gnt_id", 32'(gnt_id), 32'h2);
        tick();
        check_val("wd_idle_busy", 32'(busy), 32'h0);
        check_val("wd_idle_gnt_id", 32'(gnt_id), 32'h2);

        // Reset mid-grant: ptr is 3 here, so a retained ptr would pick requester 3
        req = 4'b0100;
        tick();
        check_val("mid_grant", 32'(grant), 32'h4);
        req = 4'b1111;
        #2;
        nRst = 1'b0;
        #1;
        check_val("mid_async_grant", 32'(grant), 32'h0);
        check_val("mid_async_busy", 32'(busy), 32'h0);
        check_val("mid_async_gnt_id", 32'(gnt_id), 32'h0);
        check_val("mid_async_timeout", 32'(timeout), 32'h0);
        #2;
        nRst = 1'b1;
        tick();
        check_val("mid_after_grant", 32'(grant), 32'h1);
        check_val("mid_after_gnt_id", 32'(gnt_id), 32'h0);

        // Long hold on requester 1
        req = 4'b0010;
        release_and_regrant("to");
        check_val("to_grant_c1", 32'(grant), 32'h2);
        check_val("to_timeout_c1", 32'(timeout), 32'h0);
`ifdef FSM_ARB_TIMEOUT_EN
        for (int c = 2; c <= MAX_HOLD; c++) begin
            tick();
            check_val("to_hold_grant", 32'(grant), 32'h2);
            check_val("to_hold_timeout", 32'(timeout), 32'h0);
        end
        tick();
        check_val("to_pulse_grant", 32'(grant), 32'h0);
        check_val("to_pulse_timeout", 32'(timeout), 32'h1);
        check_val("to_pulse_busy", 32'(busy), 32'h1);
        tick();
        check_val("to_after_timeout", 32'(timeout), 32'h0);
        check_val("to_after_busy", 32'(busy), 32'h0);
`else
        for (int c = 2; c <= MAX_HOLD + 4; c++) begin
            tick();
            check_val("hold_grant", 32'(grant), 32'h2);
            check_val("hold_timeout", 32'(timeout), 32'h0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
